// File: rtl/ipsl_pcie_seio_master.sv
`default_nettype none
// ============================================================================
// Module   : ipsl_pcie_seio_master
// Purpose  : Initiator side of the PCIe SEIO sideband link. Accepts one user
//            register write/read at a time, serialises it onto sedo/sedo_en,
//            waits for the responder's sedi_ack (with timeout) and, for
//            reads, shifts the returned data in from sedi.
// Ports    : pclk_div2 / user_rst_n      clock, async active-low reset
//            req_valid/req_ready/req_wr/req_addr/req_wdata  request channel
//            rsp_valid/rsp_rdata/rsp_err                    completion
//            sedo/sedo_en (registered), sedi/sedi_ack       serial link
// Revision : 1.0  initial release
// ============================================================================
module ipsl_pcie_seio_master #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              pclk_div2,
  input  logic              user_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              sedo,
  output logic              sedo_en,
  input  logic              sedi,
  input  logic              sedi_ack
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] C_ADDR_LEN  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] C_FRAME_LEN = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [15:0]      C_TIMEOUT   = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE0     = 3'd1,
    ST_PRE1     = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_RDATA    = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t              state_q,     state_d;
  logic                wr_q,        wr_d;
  logic [FRAME_W-1:0]  sr_q,        sr_d;
  logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [15:0]         tmo_cnt_q,   tmo_cnt_d;
  logic                sedo_q,      sedo_d;
  logic                sedo_en_q,   sedo_en_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,   rsp_err_d;

  logic [CNT_W-1:0]    shift_len;
  logic [15:0]         tmo_inc;

  // Reads only carry the address; writes carry address followed by data.
  assign shift_len = wr_q ? C_FRAME_LEN : C_ADDR_LEN;
  assign tmo_inc   = tmo_cnt_q + 16'd1;

  // The serial outputs are registered, so the comb block computes the value
  // each output must show during the *next* state rather than the current one.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    sedo_d      = 1'b0;
    sedo_en_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_PRE0;
          wr_d      = req_wr;
          sr_d      = {req_addr, req_wdata};
          bit_cnt_d = '0;
          tmo_cnt_d = '0;
          sedo_en_d = 1'b1;
          sedo_d    = ~req_wr;
        end
      end

      ST_PRE0: begin
        state_d   = ST_PRE1;
        sedo_en_d = 1'b1;
        sedo_d    = wr_q;
      end

      // Present the first frame bit while entering SHIFT; bit_cnt then
      // counts the bits already on the wire.
      ST_PRE1: begin
        state_d   = ST_SHIFT;
        sedo_en_d = 1'b1;
        sedo_d    = sr_q[FRAME_W-1];
        sr_d      = sr_q << 1;
        bit_cnt_d = CNT_W'(1);
      end

      ST_SHIFT: begin
        if (bit_cnt_q == shift_len) begin
          state_d   = ST_WAIT_ACK;
          tmo_cnt_d = '0;
        end else begin
          sedo_en_d = 1'b1;
          sedo_d    = sr_q[FRAME_W-1];
          sr_d      = sr_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      // Ack is tested before the timeout so an ack on the final cycle wins.
      ST_WAIT_ACK: begin
        tmo_cnt_d = tmo_inc;
        if (sedi_ack) begin
          if (wr_q) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
          end else begin
            state_d   = ST_RDATA;
            bit_cnt_d = '0;
          end
        end else if (tmo_inc == C_TIMEOUT) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end

      // Read data is shifted into the low end of the frame register; after
      // DATA_W samples its low DATA_W bits hold the word MSB-first.
      ST_RDATA: begin
        sr_d = {sr_q[FRAME_W-2:0], sedi};
        if (bit_cnt_q == C_DATA_LAST) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = {sr_q[DATA_W-2:0], sedi};
          rsp_err_d   = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk_div2 or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      sedo_q      <= 1'b0;
      sedo_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      sedo_q      <= sedo_d;
      sedo_en_q   <= sedo_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign sedo      = sedo_q;
  assign sedo_en   = sedo_en_q;

endmodule
`default_nettype wire

// File: doc/ipsl_pcie_seio_master.md
Name: ipsl_pcie_seio_master

Overview:
- Initiator end of the PCIe SEIO sideband link: serialises user register write/read requests onto sedo/sedo_en and collects the sedi_ack handshake.
- For reads, it also shifts back serial read data from sedi.
- Sits between user control logic and the SEIO responder, in the pclk_div2 domain.
- Provides a single-outstanding request/response interface with an ack timeout.

Parameters:
- ADDR_W, 12, address bits serialised per frame, MSB first.
- DATA_W, 32, data bits per write frame and per read return, MSB first.
- TIMEOUT_CYC, 255, maximum WAIT_ACK cycles before the error response; legal range 1..65535; counter is 16 bits.

Ports:
- pclk_div2  input  1  clock; all logic on rising edge.
- user_rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high at a clock edge.
- req_wr  input  1  1 = write, 0 = read; sampled at accept.
- req_addr  input  ADDR_W  address; sampled at accept.
- req_wdata  input  DATA_W  write data; sampled at accept, ignored for reads.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_W  read data; valid with rsp_valid; 0 for writes and on timeout.
- rsp_err  output  1  ack timeout flag; valid with rsp_valid.
- sedo  output  1  serial command/address/data to the responder; registered.
- sedo_en  output  1  frame enable; high for the whole frame; registered.
- sedi  input  1  serial read data from the responder.
- sedi_ack  input  1  responder completion pulse.

Behaviour:
- Reset values: sedo=0, sedo_en=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE (so req_ready=1), shift register=0, counters=0.
- States: IDLE, PRE0, PRE1, SHIFT, WAIT_ACK, RDATA, DONE.
- IDLE: sedo_en=0, sedo=0. On accept, latch wr/addr/wdata into the shift register; go to PRE0.
- PRE0 (1 cycle): sedo_en=1, sedo = ~req_wr, i.e. 0 for write, 1 for read.
- PRE1 (1 cycle): sedo_en=1, sedo = req_wr. This gives the responder a 0->1 edge for write and a 1->0 edge for read.
- SHIFT: sedo_en=1, drives ADDR_W address bits MSB first. For writes it then drives DATA_W data bits MSB first. The bit counter counts ADDR_W or ADDR_W+DATA_W cycles, then goes to WAIT_ACK.
- Frame length with sedo_en high: write = 2+ADDR_W+DATA_W cycles (46 at defaults); read = 2+ADDR_W cycles (14 at defaults).
- WAIT_ACK: sedo_en=0, sedo=0, timeout counter increments every cycle. The falling edge of sedo_en is the end-of-frame marker for the responder.
  - sedi_ack=1: write goes to DONE with err=0; read goes to RDATA.
  - Counter reaches TIMEOUT_CYC without ack: go to DONE with err=1 and rdata=0.
  - Ack on the same cycle the counter hits TIMEOUT_CYC: the ack wins.
- RDATA: samples sedi on DATA_W consecutive cycles starting the cycle after the ack, shifting MSB first into rdata. Then goes to DONE.
- DONE (1 cycle): rsp_valid=1 with rsp_rdata/rsp_err held; returns to IDLE. rsp_rdata and rsp_err hold their values until the next DONE.
- sedi_ack seen outside WAIT_ACK is ignored. sedi seen outside RDATA is ignored.
- Frame spacing: sedo_en is low for at least 2 cycles between frames (WAIT_ACK/DONE plus IDLE). Back-to-back frames therefore always present a clean falling edge and the idle level.
- Latency: write accept to rsp_valid = 46 + ack delay + 1 cycles.
- Reset mid-frame: all outputs go to their reset values asynchronously, sedo_en drops, no rsp_valid is issued, and the request is lost.
- req_valid while busy: held off by req_ready=0; no queueing.

Test Plan:
1. Write: addr=0xA5C, wdata=0xDEADBEEF, responder acks 4 cycles after sedo_en falls.
   -> sedo_en high for 46 cycles; sedo = 0,1, then 0xA5C MSB-first, then 0xDEADBEEF MSB-first.
   -> one rsp_valid pulse with rsp_err=0, rsp_rdata=0.
2. Read: addr=0x010, responder acks then drives 0x12345678 MSB-first on sedi.
   -> preamble 1,0; sedo_en high for 14 cycles; rsp_rdata=0x12345678, rsp_err=0.
3. Timeout: TIMEOUT_CYC=8, responder never acks.
   -> rsp_valid exactly 8 cycles after entering WAIT_ACK; rsp_err=1, rsp_rdata=0; req_ready=1 on the next cycle.
4. Back-to-back: req_valid held high for a write then a read.
   -> req_ready=0 throughout each transaction; sedo_en low for at least 2 cycles between frames; two rsp_valid pulses in order.
5. Spurious ack: sedi_ack pulsed during SHIFT.
   -> ignored, frame completes unchanged, completion waits for the real ack.
6. Reset mid-SHIFT: user_rst_n low at bit 5 of the address.
   -> sedo_en=0, sedo=0, req_ready=1 immediately, no rsp_valid; the next request completes normally.
